// File: rtl/control_block_branch.sv
// control_block_branch
//   Program-counter and decode control block for the accumulator CPU.
//   The PC addresses combinational program memory. The OpCode returned for
//   that address is decoded into Mealy datapath strobes. The block supports
//   jumps and flag branches, RAM-read wait states (mem_latency), and a HALT
//   state that can be left with resume. It also counts retired instructions.
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   OpCode, operand         instruction word from program memory
//   acc_zero, acc_neg       live accumulator flags for branches
//   resume                  leave HALT
//   address_output          registered PC
//   SelA, SelB, WrAcc, Op   accumulator/ALU control strobes
//   WrRam, RdRam            data RAM strobes
//   halted                  high while in HALT
//   retired                 completed-instruction counter
module control_block_branch #(
  parameter int bits_address = 11,
  parameter int mem_latency  = 0,
  parameter int reset_vector = 0,
  parameter int cnt_bits     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4:0]              OpCode,
  input  logic [bits_address-1:0] operand,
  input  logic                    acc_zero,
  input  logic                    acc_neg,
  input  logic                    resume,
  output logic [bits_address-1:0] address_output,
  output logic [1:0]              SelA,
  output logic                    SelB,
  output logic                    WrAcc,
  output logic                    Op,
  output logic                    WrRam,
  output logic                    RdRam,
  output logic                    halted,
  output logic [cnt_bits-1:0]     retired
);

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_JMP  = 5'b01000;
  localparam logic [4:0] OP_BEQ  = 5'b01001;
  localparam logic [4:0] OP_BNE  = 5'b01010;
  localparam logic [4:0] OP_BLT  = 5'b01011;

  localparam bit USE_WAIT = (mem_latency != 0);

  typedef enum logic [1:0] {EXEC, WAIT, HALT} state_t;

  state_t                  state_q, state_d;
  logic [bits_address-1:0] pc_q, pc_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [cnt_bits-1:0]     retired_q, retired_d;

  logic [1:0] dec_sela;
  logic       dec_selb, dec_op, dec_wracc, dec_wrram, dec_rdram;
  logic       take_branch;
  logic [bits_address-1:0] pc_inc;

  assign pc_inc = pc_q + bits_address'(1);

  always_comb begin
    dec_sela  = '0;
    dec_selb  = 1'b0;
    dec_op    = 1'b0;
    dec_wracc = 1'b0;
    dec_wrram = 1'b0;
    dec_rdram = 1'b0;
    case (OpCode)
      OP_STO: dec_wrram = 1'b1;
      OP_LD: begin
        dec_rdram = 1'b1;
        dec_wracc = 1'b1;
      end
      OP_LDI: begin
        dec_sela  = 2'b01;
        dec_wracc = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        dec_rdram = 1'b1;
        dec_sela  = 2'b10;
        dec_wracc = 1'b1;
        dec_op    = (OpCode == OP_SUB);
      end
      OP_ADDI, OP_SUBI: begin
        dec_selb  = 1'b1;
        dec_sela  = 2'b10;
        dec_wracc = 1'b1;
        dec_op    = (OpCode == OP_SUBI);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (OpCode)
      OP_JMP:  take_branch = 1'b1;
      OP_BEQ:  take_branch = acc_zero;
      OP_BNE:  take_branch = !acc_zero;
      OP_BLT:  take_branch = acc_neg;
      default: take_branch = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    retired_d = retired_q;
    SelA      = '0;
    SelB      = 1'b0;
    WrAcc     = 1'b0;
    Op        = 1'b0;
    WrRam     = 1'b0;
    RdRam     = 1'b0;
    unique case (state_q)
      EXEC: begin
        if (OpCode == OP_HLT) begin
          state_d   = HALT;
          retired_d = retired_q + cnt_bits'(1);
        end else if (USE_WAIT && dec_rdram) begin
          // The first cycle of a slow read only issues the read. Operand
          // selects and the write follow in WAIT, once data is valid.
          RdRam   = 1'b1;
          state_d = WAIT;
          cnt_d   = 2'(mem_latency);
        end else begin
          SelA      = dec_sela;
          SelB      = dec_selb;
          WrAcc     = dec_wracc;
          Op        = dec_op;
          WrRam     = dec_wrram;
          RdRam     = dec_rdram;
          pc_d      = take_branch ? operand : pc_inc;
          retired_d = retired_q + cnt_bits'(1);
        end
      end
      WAIT: begin
        SelA  = dec_sela;
        SelB  = dec_selb;
        Op    = dec_op;
        RdRam = 1'b1;
        WrAcc = (cnt_q == 2'd1);
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          pc_d      = pc_inc;
          retired_d = retired_q + cnt_bits'(1);
          state_d   = EXEC;
        end
      end
      HALT: begin
        if (resume) begin
          pc_d    = pc_inc;
          state_d = EXEC;
        end
      end
      default: state_d = EXEC;
    endcase
    if (reset) begin
      SelA  = '0;
      SelB  = 1'b0;
      WrAcc = 1'b0;
      Op    = 1'b0;
      WrRam = 1'b0;
      RdRam = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EXEC;
      pc_q      <= bits_address'(reset_vector);
      cnt_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
    end
  end

  assign address_output = pc_q;
  assign retired        = retired_q;
  assign halted         = (state_q == HALT);

endmodule

// File: doc/control_block_branch.md
Name: control_block_branch

Overview:
- Parametrised successor to the accumulator-CPU control block.
- Holds the program counter and decodes the 5-bit opcode into datapath strobes.
- Adds synchronous reset, absolute jump and conditional branches on accumulator flags, configurable RAM read latency with wait states, a HALT state with resume, and a retired-instruction counter.
- Sits between program memory (address out, opcode/operand in) and the accumulator datapath/data RAM.

Parameters:
- bits_address, 11, width of PC, address_output and operand.
- mem_latency, 0, extra wait cycles for data-RAM reads (0..3); 0 gives single-cycle execution.
- reset_vector, 0, PC value loaded on reset.
- cnt_bits, 16, width of retired counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- OpCode  in  5  instruction opcode at address_output (combinational program memory).
- operand  in  bits_address  instruction operand/immediate; branch target.
- acc_zero  in  1  accumulator == 0.
- acc_neg  in  1  accumulator MSB.
- resume  in  1  leave HALT.
- address_output  out  bits_address  registered PC.
- SelA  out  2  accumulator source: 00 RAM, 01 immediate, 10 ALU.
- SelB  out  1  ALU operand B: 0 RAM, 1 immediate.
- WrAcc  out  1  accumulator write enable.
- Op  out  1  ALU op: 0 add, 1 sub.
- WrRam  out  1  data RAM write.
- RdRam  out  1  data RAM read.
- halted  out  1  high in HALT.
- retired  out  cnt_bits  count of completed instructions.

Behaviour:
- Reset, sync on clk edge:
  - PC=reset_vector, state=EXEC, wait counter=0, retired=0, halted=0.
  - All strobes forced 0 during a reset cycle.
  - Reset overrides every other event in any state, including mid-WAIT.
- States: EXEC, WAIT, HALT.
- Strobe outputs are Mealy (state + OpCode). PC and retired are registered.
- Decode in EXEC:
  - 00000 HLT: all strobes 0; next state HALT; PC holds.
  - 00001 STO: WrRam=1.
  - 00010 LD: RdRam=1, SelA=00, WrAcc=1.
  - 00011 LDI: SelA=01, WrAcc=1.
  - 00100 ADD: RdRam=1, SelB=0, Op=0, SelA=10, WrAcc=1.
  - 00101 ADDI: SelB=1, Op=0, SelA=10, WrAcc=1.
  - 00110 SUB: as ADD with Op=1.
  - 00111 SUBI: as ADDI with Op=1.
  - 01000 JMP: PC<=operand.
  - 01001 BEQ: PC<=operand if acc_zero, else PC+1.
  - 01010 BNE: PC<=operand if !acc_zero, else PC+1.
  - 01011 BLT: PC<=operand if acc_neg, else PC+1.
  - Other opcodes: NOP (all strobes 0), PC+1.
  - Non-asserted strobes are 0; SelA, SelB and Op are 0 when unused.
- RAM-read instructions (LD, ADD, SUB):
  - mem_latency=0: complete in one EXEC cycle, same as the other instructions.
  - mem_latency=N>0: the EXEC cycle asserts RdRam only (WrAcc=0) and enters WAIT with counter=N.
  - WAIT holds RdRam=1, SelA/SelB/Op per opcode, PC frozen; counter decrements each cycle.
  - WrAcc=1 only in the WAIT cycle where counter==1. On that edge PC+1, retired+1, state EXEC.
  - Total cycles per such instruction = N+1.
- PC arithmetic: PC+1 is modulo 2^bits_address (max wraps to 0). Branch targets are taken verbatim.
- Retired counter:
  - Increments on the edge that completes any instruction except HLT.
  - HLT counts once, on entry to HALT.
  - Wraps modulo 2^cnt_bits.
- HALT:
  - halted=1; all strobes 0; PC holds the HLT address.
  - resume=1 sampled in HALT: PC<=PC+1, state EXEC, halted=0 next cycle.
  - resume is ignored outside HALT.
  - reset and resume in the same cycle: reset wins.
- Flags acc_zero and acc_neg are sampled in the branch's EXEC cycle only; the datapath must present them combinationally from the current accumulator.

Test Plan:
- Reset then program LDI 5, ADDI 3, STO 7 with mem_latency=0 -> address_output 0,1,2,3 on successive cycles; WrAcc high at cycles 0 and 1, SelA=01 then 10, WrRam only at cycle 2; retired=3.
- mem_latency=2, ADD at PC=4 -> RdRam high 3 cycles, WrAcc high only on the third, PC=4 for 3 cycles then 5; retired +1.
- BEQ operand=0x123 with acc_zero=1 -> next PC=0x123; repeat with acc_zero=0 at PC=0x010 -> next PC=0x011. Same pair of checks for BNE and BLT using acc_neg.
- PC=0x7FF (bits_address=11) executing NOP -> next PC=0x000; retired increments.
- HLT at PC=9 -> halted=1, PC stays 9 for 20 cycles with strobes 0; pulse resume -> PC=10, halted=0.
- Assert reset mid-WAIT (mem_latency=3, second wait cycle) -> next cycle PC=reset_vector, WrAcc never asserted, retired=0, state EXEC.
